// File: rtl/pmod_dac_stream.sv
// Multi-lane serial DAC streamer: frames each channel sample as a 16-bit word and shifts it
// out MSB first on a shared SCLK/NSYNC, with optional continuous retransmit of the last set.
module pmod_dac_stream #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic [N_CH*DATA_W-1:0]   i_s_data,
  input  logic [1:0]               i_pd_mode,
  input  logic                     i_repeat_en,
  output logic                     o_sclk,
  output logic [N_CH-1:0]          o_sdata,
  output logic                     o_nsync,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned Pad  = 12 - DATA_W;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e                  r_state, w_state_d;
  logic [DivW-1:0]         r_div, w_div_d;
  logic [4:0]              r_phase, w_phase_d;
  logic [GapW-1:0]         r_gap, w_gap_d;
  logic [N_CH-1:0][15:0]   r_shreg, w_shreg_d;
  logic [N_CH*DATA_W-1:0]  r_hold_data, w_hold_data_d;
  logic [1:0]              r_hold_pd, w_hold_pd_d;
  logic                    r_held, w_held_d;
  logic                    r_sclk, w_sclk_d;
  logic [N_CH-1:0]         r_sdata, w_sdata_d;
  logic                    r_nsync, w_nsync_d;
  logic                    r_busy, w_busy_d;
  logic                    r_done, w_done_d;

  logic                    w_accept, w_repeat;
  logic [N_CH*DATA_W-1:0]  w_src_data;
  logic [1:0]              w_src_pd;

  function automatic logic [15:0] build_frame(input logic [1:0] pd, input logic [DATA_W-1:0] s);
    logic [11:0] just;
    just = 12'(s) << Pad;
    return {2'b00, pd, just};
  endfunction

  // A fresh set always wins over an auto-repeat in the same IDLE cycle.
  assign w_accept   = (r_state == StIdle) && i_s_valid;
  assign w_repeat   = (r_state == StIdle) && !i_s_valid && i_repeat_en && r_held;
  assign w_src_data = w_accept ? i_s_data : r_hold_data;
  assign w_src_pd   = w_accept ? i_pd_mode : r_hold_pd;

  always_comb begin
    w_state_d     = r_state;
    w_div_d       = r_div;
    w_phase_d     = r_phase;
    w_gap_d       = r_gap;
    w_shreg_d     = r_shreg;
    w_hold_data_d = r_hold_data;
    w_hold_pd_d   = r_hold_pd;
    w_held_d      = r_held;
    w_done_d      = 1'b0;
    w_sclk_d      = 1'b1;
    w_nsync_d     = 1'b1;
    w_sdata_d     = '0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_hold_data_d = i_s_data;
          w_hold_pd_d   = i_pd_mode;
          w_held_d      = 1'b1;
        end
        if (w_accept || w_repeat) begin
          w_state_d = StShift;
          w_div_d   = '0;
          w_phase_d = '0;
          for (int c = 0; c < N_CH; c++) begin
            w_shreg_d[c] = build_frame(w_src_pd, w_src_data[c*DATA_W +: DATA_W]);
          end
        end
      end
      StShift: begin
        if (r_div == DivW'(CLK_DIV - 1)) begin
          w_div_d = '0;
          if (r_phase == 5'd31) begin
            w_state_d = StGap;
            w_gap_d   = '0;
          end else begin
            w_phase_d = r_phase + 5'd1;
            // Advance to the next bit only after the falling half of SCLK.
            if (r_phase[0]) begin
              for (int c = 0; c < N_CH; c++) begin
                w_shreg_d[c] = {r_shreg[c][14:0], 1'b0};
              end
            end
          end
        end else begin
          w_div_d = r_div + 1'b1;
        end
      end
      StGap: begin
        if (r_gap == GapW'(GAP_CYC - 1)) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end else begin
          w_gap_d = r_gap + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_state_d == StShift) begin
      w_nsync_d = 1'b0;
      w_sclk_d  = ~w_phase_d[0];
      for (int c = 0; c < N_CH; c++) begin
        w_sdata_d[c] = w_shreg_d[c][15];
      end
    end
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_div       <= '0;
      r_phase     <= '0;
      r_gap       <= '0;
      r_shreg     <= '0;
      r_hold_data <= '0;
      r_hold_pd   <= '0;
      r_held      <= 1'b0;
      r_sclk      <= 1'b1;
      r_sdata     <= '0;
      r_nsync     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_div       <= w_div_d;
      r_phase     <= w_phase_d;
      r_gap       <= w_gap_d;
      r_shreg     <= w_shreg_d;
      r_hold_data <= w_hold_data_d;
      r_hold_pd   <= w_hold_pd_d;
      r_held      <= w_held_d;
      r_sclk      <= w_sclk_d;
      r_sdata     <= w_sdata_d;
      r_nsync     <= w_nsync_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  // Ready must drop in the same cycle reset is asserted, so it is gated by the live reset input.
  assign o_s_ready    = (r_state == StIdle) && i_rst_n;
  assign o_sclk       = r_sclk;
  assign o_sdata      = r_sdata;
  assign o_nsync      = r_nsync;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule

// File: doc/pmod_dac_stream.md
PMOD_DAC_STREAM -- requirements
Module: pmod_dac_stream

Interface
REQ-001 Parameter N_CH, default 2: number of DAC channels; each channel has its own SDATA lane and all lanes share SCLK and NSYNC.
REQ-002 Parameter DATA_W, default 12: sample width per channel; legal range 1..12.
REQ-003 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range is 1 or more.
REQ-004 Parameter GAP_CYC, default 2: clk cycles with NSYNC high between frames; legal range is 1 or more.
REQ-005 clk  in  1  the single clock domain; all outputs are registered on its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 s_valid  in  1  sample-set valid.
REQ-008 s_ready  out  1  block can accept a sample set.
REQ-009 s_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
REQ-010 pd_mode  in  2  DAC power-down bits; captured with s_data.
REQ-011 repeat_en  in  1  when high, the last accepted set is retransmitted continuously while no new set is offered.
REQ-012 SCLK  out  1  serial clock; idles high.
REQ-013 SDATA  out  N_CH  serial data, one bit per channel, MSB first.
REQ-014 NSYNC  out  1  frame sync, active low.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 frame_done  out  1  single-cycle pulse when a frame, including its gap, completes.

Function
REQ-017 The block SHALL implement the states IDLE, SHIFT and GAP.
REQ-018 s_ready SHALL be high only in IDLE while rst is high; a set is accepted on a cycle with s_valid && s_ready.
REQ-019 On acceptance, or on an auto-repeat start, the block SHALL load the 16-bit frame for each channel and move to SHIFT on the next cycle.
REQ-020 The 16-bit frame SHALL be {2'b00, pd_mode, sample, (12-DATA_W) zero bits}, i.e. the sample is left-justified in bits [11:0].
REQ-021 Let T be the start cycle and k = 0..32*CLK_DIV-1 index cycles T+1 onward; during that window NSYNC SHALL be 0.
REQ-022 During SHIFT, SCLK SHALL be 1 when floor(k/CLK_DIV) is even and 0 otherwise, giving 16 falling edges at k=(2i+1)*CLK_DIV for i=0..15.
REQ-023 Bit 15-i of the frame SHALL be driven on SDATA for k in [2i*CLK_DIV, (2i+2)*CLK_DIV-1], so data is stable across every falling edge.
REQ-024 After k=32*CLK_DIV-1 the block SHALL enter GAP for GAP_CYC cycles with NSYNC=1, SCLK=1 and SDATA=0.
REQ-025 After GAP the block SHALL return to IDLE, and frame_done SHALL be 1 in the first IDLE cycle (T+32*CLK_DIV+GAP_CYC+1).
REQ-026 Start-to-start spacing for back-to-back frames SHALL be 32*CLK_DIV+GAP_CYC+1 cycles.
REQ-027 Auto-repeat: in IDLE with repeat_en=1, held data valid and s_valid=0, a frame of the held set and pd_mode SHALL start; s_ready stays high in that cycle.
REQ-028 If s_valid=1 in that same IDLE cycle, the new set SHALL win and replace the held set.
REQ-029 Changes on s_data, pd_mode or s_valid outside an accept SHALL NOT affect a frame in progress.
REQ-030 Deasserting repeat_en mid-frame SHALL let the current frame finish, with no further repeats.
REQ-031 In IDLE: NSYNC=1, SCLK=1, SDATA=0.

Reset
REQ-032 While rst=0 at a clk edge, the outputs SHALL be: state IDLE, NSYNC=1, SCLK=1, SDATA=0, s_ready=0, busy=0, frame_done=0; the held-data flag SHALL be cleared.
REQ-033 Reset mid-frame SHALL abort the frame immediately, with no frame_done; after reset no auto-repeat occurs until a new set is accepted.
REQ-034 s_ready SHALL be 1 in the first cycle with rst=1.

Verification (defaults N_CH=2, DATA_W=12, CLK_DIV=4, GAP_CYC=2)
REQ-035 Accept ch0=0xABC, ch1=0x123, pd=00 at T -> 16 falling-edge samples read 0x0ABC on SDATA[0] and 0x0123 on SDATA[1]; NSYNC low T+1..T+128; frame_done at T+131.
REQ-036 pd_mode=2'b11, data=0xFFF -> frame 0x3FFF on both lanes.
REQ-037 s_valid held high with new data each accept -> NSYNC falls every 131 cycles; every set is transmitted exactly once, in order.
REQ-038 repeat_en=1 after one accept of 0x555, s_valid=0 -> identical 0x0555 frames every 131 cycles; s_valid with 0x2AA during a frame -> accepted in the next IDLE cycle and repeated from then on.
REQ-039 rst=0 at k=50 of a frame -> next cycle NSYNC=1, SCLK=1, no frame_done, no repeat after release even with repeat_en=1.
REQ-040 DATA_W=8, CLK_DIV=1, N_CH=4 -> sample 0xA5 yields frame 0x0A50 on each lane; SCLK period 2 cycles; NSYNC low 32 cycles.
